// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
// Iterative unsigned multiply/divide unit for the EX stage. It takes one
// operation at a time from the ID/EX register outputs. A radix-2 shift-add
// multiply or restoring divide runs for XLEN cycles. While the unit is
// busy it holds the upstream stages with a stall. When the operation ends
// it gives a one-cycle result pulse to EX/MEM.
//
// Optional build macro: MULDIV_EARLY_OUT_EN
//   When defined, an operation that has a zero operand skips the iteration
//   phase and goes straight to DONE.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   start        ID/EX holds a valid muldiv instruction
//   op           00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   readdata1    rs1 operand (multiplicand / dividend)
//   readdata2    rs2 operand (multiplier / divisor)
//   rd_in        destination register of the instruction
//   flush        kills any in-flight operation
//   stall        freezes PC, IF/ID and ID/EX
//   done         one-cycle result-valid pulse
//   result       operation result, zero unless done
//   rd_out       destination register, zero unless done
//   regwrite_out done and rd_out != 0
module ex_muldiv_unit #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] readdata1,
    input  logic [XLEN-1:0] readdata2,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            regwrite_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [1:0]          op_r;
    logic [4:0]          rd_r;
    // Multiplicand for multiply, divisor for divide.
    logic [XLEN-1:0]     opnd_r;
    // Upper half: product accumulator / remainder.
    // Lower half: multiplier being shifted out / quotient being shifted in.
    logic [2*XLEN-1:0]   acc_r;

    logic                accept_s;
    logic                early_s;
    logic                last_iter_s;
    logic [2*XLEN-1:0]   acc_init_s;
    logic [XLEN-1:0]     opnd_init_s;
    logic [2*XLEN-1:0]   acc_iter_s;
    logic [XLEN:0]       mul_sum_s;
    logic [XLEN:0]       div_shift_s;
    logic [XLEN:0]       div_diff_s;
    logic                done_s;

    // Accept a new operation only from IDLE when it is not being flushed.
    always_comb begin
        accept_s    = (state_r == IDLE) && start && !flush && !reset;
        last_iter_s = (cnt_r == CNT_W'(XLEN - 1));
    end

    // Initial operand placement, and the early-out decision when that build option is enabled.
    always_comb begin
        acc_init_s  = {2*XLEN{1'b0}};
        opnd_init_s = {XLEN{1'b0}};
        early_s     = 1'b0;
        if (op[1]) begin
            acc_init_s  = {{XLEN{1'b0}}, readdata1};
            opnd_init_s = readdata2;
        end else begin
            acc_init_s  = {{XLEN{1'b0}}, readdata2};
            opnd_init_s = readdata1;
        end
`ifdef MULDIV_EARLY_OUT_EN
        early_s = (readdata1 == {XLEN{1'b0}}) || (readdata2 == {XLEN{1'b0}});
        if (early_s) begin
            // The divisor-zero case is checked first. This gives the same
            // answer the full iteration would give when both operands are zero.
            if (op[1] && (readdata2 == {XLEN{1'b0}})) begin
                acc_init_s = {readdata1, {XLEN{1'b1}}};
            end else begin
                acc_init_s = {2*XLEN{1'b0}};
            end
        end else begin
            acc_init_s = acc_init_s;
        end
`else
        early_s = 1'b0;
`endif
    end

    // One radix-2 step: shift-add for multiply, or restoring shift-subtract for divide.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]};
        div_shift_s = acc_r[2*XLEN-1:XLEN-1];
        div_diff_s  = div_shift_s - {1'b0, opnd_r};
        acc_iter_s  = acc_r;
        if (op_r[1]) begin
            // A set bit XLEN in the difference means the trial subtract borrowed.
            if (!div_diff_s[XLEN]) begin
                acc_iter_s = {div_diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
            end else begin
                acc_iter_s = {div_shift_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
            end
        end else begin
            if (acc_r[0]) begin
                mul_sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]} + {1'b0, opnd_r};
            end else begin
                mul_sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]};
            end
            acc_iter_s = {mul_sum_s, acc_r[XLEN-1:1]};
        end
    end

    // Next-state logic. flush returns the FSM to IDLE from any active state.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = early_s ? DONE : BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_next_s = IDLE;
                end else if (last_iter_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operation registers: latched on accept, then iterated while BUSY.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r  <= {CNT_W{1'b0}};
            op_r   <= 2'b00;
            rd_r   <= 5'd0;
            opnd_r <= {XLEN{1'b0}};
            acc_r  <= {2*XLEN{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        cnt_r  <= {CNT_W{1'b0}};
                        op_r   <= op;
                        rd_r   <= rd_in;
                        opnd_r <= opnd_init_s;
                        acc_r  <= acc_init_s;
                    end
                end
                BUSY: begin
                    if (!flush) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                        acc_r <= acc_iter_s;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Outputs. A flush in the DONE cycle suppresses the pulse, and every
    // field reads zero outside the pulse. The odd op codes (MULHU, REMU)
    // select the upper half of the accumulator.
    always_comb begin
        done_s       = (state_r == DONE) && !flush;
        stall        = accept_s || ((state_r == BUSY) && !reset);
        done         = done_s;
        result       = {XLEN{1'b0}};
        rd_out       = 5'd0;
        regwrite_out = 1'b0;
        if (done_s) begin
            result       = op_r[0] ? acc_r[2*XLEN-1:XLEN] : acc_r[XLEN-1:0];
            rd_out       = rd_r;
            regwrite_out = (rd_r != 5'd0);
        end else begin
            result       = {XLEN{1'b0}};
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit. It runs directed and random
// operations and compares the results with an arithmetic reference model.
// It also checks the timing of stall and done, and the behaviour under
// flush and asynchronous reset.
module tb_ex_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [63:0] readdata1;
    logic [63:0] readdata2;
    logic [4:0]  rd_in;
    logic        flush;
    logic        stall;
    logic        done;
    logic [63:0] result;
    logic [4:0]  rd_out;
    logic        regwrite_out;

    int n_checks = 0;
    int n_fail   = 0;

    ex_muldiv_unit #(.XLEN(64), .CNT_W(7)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .op           (op),
        .readdata1    (readdata1),
        .readdata2    (readdata2),
        .rd_in        (rd_in),
        .flush        (flush),
        .stall        (stall),
        .done         (done),
        .result       (result),
        .rd_out       (rd_out),
        .regwrite_out (regwrite_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog on total run time.
    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model in plain arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        p = {64'd0, a} * {64'd0, b};
        case (o)
            2'b00:   return p[63:0];
            2'b01:   return p[127:64];
            2'b10:   return (b == 64'd0) ? {64{1'b1}} : a / b;
            default: return (b == 64'd0) ? a : a % b;
        endcase
    endfunction

    // Number of cycles between the accept edge and the done cycle.
    function automatic int exp_latency(input logic [63:0] a, input logic [63:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        return ((a == 64'd0) || (b == 64'd0)) ? 0 : 64;
`else
        return (a == b + a - b) ? 64 : 64;
`endif
    endfunction

    // Present an instruction on the next cycle and step past its accept edge.
    task automatic issue(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
        @(posedge clk); #1;
        check("single done pulse", 64'(done), 64'd0);
        start = 1'b1; op = o; readdata1 = a; readdata2 = b; rd_in = rd;
        #1;
        check("stall in accept cycle", 64'(stall), 64'd1);
        @(posedge clk); #1;
    endtask

    // Wait a bounded time for done, then check the latency, the stall count and the outputs.
    task automatic wait_done(input string tag, input logic [1:0] o, input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
        int k;
        int stalls;
        bit seen;
        stalls = 0;
        seen   = 1'b0;
        for (k = 0; k < 200; k++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (stall === 1'b1) stalls++;
            @(posedge clk); #1;
        end
        check({tag, " done seen"}, 64'(seen), 64'd1);
        check({tag, " latency"}, 64'(k), 64'(exp_latency(a, b)));
        check({tag, " stall cycles"}, 64'(stalls), 64'(exp_latency(a, b)));
        check({tag, " result"}, result, model(o, a, b));
        check({tag, " rd_out"}, 64'(rd_out), 64'(rd));
        check({tag, " regwrite_out"}, 64'(regwrite_out), 64'(rd != 5'd0));
        check({tag, " stall in done"}, 64'(stall), 64'd0);
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
        issue(o, a, b, rd);
        start = 1'b0;
        wait_done(tag, o, a, b, rd);
    endtask

    // Step n cycles and report whether a done pulse appeared.
    task automatic expect_quiet(input string tag, input int n);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0) seen = 1'b1;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [63:0] r_a;
        logic [63:0] r_b;
        logic [4:0]  r_rd;

        reset = 1'b1; start = 1'b0; op = 2'b00; readdata1 = 64'd0;
        readdata2 = 64'd0; rd_in = 5'd0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("reset stall", 64'(stall), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset result", result, 64'd0);
        check("reset rd_out", 64'(rd_out), 64'd0);
        check("reset regwrite_out", 64'(regwrite_out), 64'd0);

        // Directed arithmetic cases.
        run("mul 7x6", 2'b00, 64'd7, 64'd6, 5'd5);
        run("mulhu max x2", 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd9);
        run("mul max x2", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd10);
        run("divu 100/7", 2'b10, 64'd100, 64'd7, 5'd11);
        run("remu 100/7", 2'b11, 64'd100, 64'd7, 5'd12);
        run("divu 5/0", 2'b10, 64'd5, 64'd0, 5'd13);
        run("remu 5/0", 2'b11, 64'd5, 64'd0, 5'd14);
        run("divu 0/9", 2'b10, 64'd0, 64'd9, 5'd15);
        run("mul 0x3", 2'b00, 64'd0, 64'd3, 5'd16);

        // start is held through DONE; the next instruction comes right after, with rd=0.
        issue(2'b00, 64'd5, 64'd5, 5'd3);
        wait_done("hold start", 2'b00, 64'd5, 64'd5, 5'd3);
        issue(2'b00, 64'd3, 64'd4, 5'd0);
        start = 1'b0;
        wait_done("rd0 back-to-back", 2'b00, 64'd3, 64'd4, 5'd0);

        // Flush during BUSY cycle 30.
        issue(2'b10, 64'hDEAD_BEEF_1234_5678, 64'd12345, 5'd7);
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        check("flush busy stall", 64'(stall), 64'd0);
        check("flush busy done", 64'(done), 64'd0);
        expect_quiet("flush busy no done", 70);

        // Flush in the DONE cycle.
        issue(2'b00, 64'd9, 64'd9, 5'd4);
        start = 1'b0;
        repeat (64) @(posedge clk);
        #1;
        check("flush done pre", 64'(done), 64'd1);
        flush = 1'b1;
        #1;
        check("flush done done", 64'(done), 64'd0);
        check("flush done result", result, 64'd0);
        check("flush done regwrite", 64'(regwrite_out), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        check("after flush done stall", 64'(stall), 64'd0);

        // Flush in IDLE blocks acceptance of start.
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; op = 2'b00; readdata1 = 64'd2; readdata2 = 64'd2; rd_in = 5'd1;
        #1;
        check("idle flush stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        #1;
        check("idle flush not accepted", 64'(stall), 64'd0);
        expect_quiet("idle flush no done", 70);

        // Asynchronous reset asserted mid-cycle during BUSY cycle 10.
        issue(2'b01, 64'h0123_4567_89AB_CDEF, 64'h0FED_CBA9_8765_4321, 5'd2);
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async reset stall", 64'(stall), 64'd0);
        check("async reset done", 64'(done), 64'd0);
        @(posedge clk); #2;
        reset = 1'b0;
        expect_quiet("after reset no done", 70);
        run("mul 3x3 after reset", 2'b00, 64'd3, 64'd3, 5'd6);

        // Random operations.
        for (int i = 0; i < 10; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = {$urandom, $urandom};
            r_b  = {$urandom, $urandom};
            if (i % 3 == 1) r_b = 64'($urandom_range(0, 20));
            if (i % 4 == 3) r_a = 64'($urandom_range(0, 3));
            r_rd = 5'($urandom_range(0, 31));
            run("random op", r_op, r_a, r_b, r_rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
